// File: rtl/mcdatamem_if.sv
// CPU data-port bus between a CPU (master) and the multi-cycle data memory (slave).
// Carries the request, its operands, and the registered completion result.
interface mcdatamem_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] datain;
    logic [31:0] dataout;
    logic        ready;
    logic        err;

    modport master (output req, we, addr, datain, input dataout, ready, err);
    modport slave  (input req, we, addr, datain, output dataout, ready, err);
endinterface

// File: rtl/mcdatamem.sv
// Multi-cycle word data memory: accepts one load/store, inserts WAIT wait states,
// commits, then pulses ready for one cycle with dataout/err.
module mcdatamem #(
    parameter int DEPTH = 32,
    parameter int WAIT  = 2
) (
    input  logic        clk,
    input  logic        clrn,
    mcdatamem_if.slave  bus
);
    localparam int CW = (WAIT > 0) ? $clog2(WAIT + 1) : 1;
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] WAIT_C = CW'(WAIT);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          we_q, we_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   datain_q, datain_d;
    logic [31:0]   dataout_q, dataout_d;
    logic          err_q, err_d;

    logic          commit;
    logic          legal;
    logic [IW-1:0] word_idx;
    logic [31:0]   mem_rd [DEPTH];
    logic [31:0]   rd_word;

    assign commit   = (state_q == BUSY) && (cnt_q == '0);
    // Full 30-bit word-index compare so high address bits never alias into the array.
    assign legal    = (addr_q[1:0] == 2'b00) && ({2'b00, addr_q[31:2]} < 32'(DEPTH));
    assign word_idx = addr_q[IW+1:2];
    assign rd_word  = mem_rd[word_idx];

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_word
            logic [31:0] word_q, word_d;

            always_comb begin
                word_d = word_q;
                if (commit && legal && we_q && (word_idx == IW'(gi)))
                    word_d = datain_q;
            end

            always_ff @(posedge clk or negedge clrn) begin
                if (!clrn) word_q <= '0;
                else       word_q <= word_d;
            end

            assign mem_rd[gi] = word_q;
        end
    endgenerate

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        we_d      = we_q;
        addr_d    = addr_q;
        datain_d  = datain_q;
        dataout_d = dataout_q;
        err_d     = err_q;
        case (state_q)
            IDLE: begin
                if (bus.req) begin
                    we_d     = bus.we;
                    addr_d   = bus.addr;
                    datain_d = bus.datain;
                    cnt_d    = WAIT_C;
                    state_d  = BUSY;
                end
            end
            BUSY: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    state_d = DONE;
                    if (legal) begin
                        dataout_d = we_q ? datain_q : rd_word;
                        err_d     = 1'b0;
                    end else begin
                        dataout_d = '0;
                        err_d     = 1'b1;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            datain_q  <= '0;
            dataout_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            datain_q  <= datain_d;
            dataout_q <= dataout_d;
            err_q     <= err_d;
        end
    end

    assign bus.ready   = (state_q == DONE);
    assign bus.dataout = dataout_q;
    assign bus.err     = err_q;
endmodule

// File: tb/tb_mcdatamem.sv
// Directed bench for mcdatamem: vector table on a WAIT=2 instance plus hand-written
// reset-abort, back-to-back and WAIT=0 sequences.
module tb_mcdatamem;
    logic clk;
    logic clrn;
    int   total;
    int   bad;

    mcdatamem_if b2();
    mcdatamem_if b0();

    mcdatamem #(.DEPTH(32), .WAIT(2)) u_w2 (.clk(clk), .clrn(clrn), .bus(b2.slave));
    mcdatamem #(.DEPTH(32), .WAIT(0)) u_w0 (.clk(clk), .clrn(clrn), .bus(b0.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] din;
        logic [31:0] exp_dout;
        logic        exp_err;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input int which, input logic req, input logic we,
                         input logic [31:0] a, input logic [31:0] d);
        if (which == 0) begin
            b0.req = req; b0.we = we; b0.addr = a; b0.datain = d;
        end else begin
            b2.req = req; b2.we = we; b2.addr = a; b2.datain = d;
        end
    endtask

    task automatic sample(input int which, output logic rdy, output logic [31:0] dout,
                          output logic e);
        if (which == 0) begin
            rdy = b0.ready; dout = b0.dataout; e = b0.err;
        end else begin
            rdy = b2.ready; dout = b2.dataout; e = b2.err;
        end
    endtask

    // One access: accepted at the next edge; latency counts edges until ready is seen.
    task automatic run_access(input int which, input logic we, input logic [31:0] a,
                              input logic [31:0] d, output logic [31:0] dout,
                              output logic e, output int lat, output logic rdy_after);
        logic rdy;
        lat  = -1;
        dout = 'x;
        e    = 1'bx;
        @(negedge clk);
        drive(which, 1'b1, we, a, d);
        @(posedge clk);
        #1;
        drive(which, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            sample(which, rdy, dout, e);
            if (rdy) begin
                lat = i;
                break;
            end
        end
        @(posedge clk);
        #1;
        sample(which, rdy_after, dout, e);
        sample(which, rdy, dout, e);
    endtask

    logic [31:0] dout;
    logic        e;
    logic        rdy;
    logic        rdy_after;
    int          lat;
    int          seen;

    initial begin
        total = 0;
        bad   = 0;
        drive(0, 1'b0, 1'b0, '0, '0);
        drive(2, 1'b0, 1'b0, '0, '0);
        clrn = 1'b0;
        #23;
        sample(2, rdy, dout, e);
        check("reset_ready", {31'b0, rdy}, 32'd0);
        check("reset_dout", dout, 32'd0);
        check("reset_err", {31'b0, e}, 32'd0);
        sample(0, rdy, dout, e);
        check("reset_ready_w0", {31'b0, rdy}, 32'd0);
        check("reset_dout_w0", dout, 32'd0);
        @(negedge clk);
        clrn = 1'b1;

        vecs[0]  = '{1'b1, 32'h0000_0008, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0};
        vecs[1]  = '{1'b0, 32'h0000_0008, 32'h0,         32'hDEAD_BEEF, 1'b0};
        vecs[2]  = '{1'b1, 32'h0000_0006, 32'h1234_5678, 32'h0,         1'b1};
        vecs[3]  = '{1'b0, 32'h0000_0004, 32'h0,         32'h0,         1'b0};
        vecs[4]  = '{1'b0, 32'h0000_0080, 32'h0,         32'h0,         1'b1};
        vecs[5]  = '{1'b0, 32'h8000_0000, 32'h0,         32'h0,         1'b1};
        vecs[6]  = '{1'b1, 32'h0000_007C, 32'h1122_3344, 32'h1122_3344, 1'b0};
        vecs[7]  = '{1'b0, 32'h0000_007C, 32'h0,         32'h1122_3344, 1'b0};
        vecs[8]  = '{1'b1, 32'h0000_0104, 32'hAAAA_5555, 32'h0,         1'b1};
        vecs[9]  = '{1'b0, 32'h0000_0004, 32'h0,         32'h0,         1'b0};
        vecs[10] = '{1'b1, 32'h0000_0007, 32'h7777_7777, 32'h0,         1'b1};
        vecs[11] = '{1'b0, 32'h0000_0008, 32'h0,         32'hDEAD_BEEF, 1'b0};

        for (int v = 0; v < 12; v++) begin
            run_access(2, vecs[v].we, vecs[v].addr, vecs[v].din, dout, e, lat, rdy_after);
            check($sformatf("vec%0d_lat", v), 32'(lat), 32'd3);
            check($sformatf("vec%0d_dout", v), dout, vecs[v].exp_dout);
            check($sformatf("vec%0d_err", v), {31'b0, e}, {31'b0, vecs[v].exp_err});
            check($sformatf("vec%0d_single_pulse", v), {31'b0, rdy_after}, 32'd0);
            $display("vec%0d we=%0d addr=0x%08h din=0x%08h -> dout=0x%08h err=%0d lat=%0d",
                     v, vecs[v].we, vecs[v].addr, vecs[v].din, dout, e, lat);
        end

        // Reset one cycle into the wait states aborts the store.
        @(negedge clk);
        drive(2, 1'b1, 1'b1, 32'h0000_0010, 32'hCAFE_F00D);
        @(posedge clk);
        #1;
        drive(2, 1'b0, 1'b0, '0, '0);
        @(posedge clk);
        #1;
        clrn = 1'b0;
        #1;
        sample(2, rdy, dout, e);
        check("abort_dout", dout, 32'd0);
        check("abort_err", {31'b0, e}, 32'd0);
        @(posedge clk);
        #1;
        clrn = 1'b1;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            if (b2.ready) seen++;
        end
        check("abort_no_ready", 32'(seen), 32'd0);
        $display("abort sequence: ready pulses after reset=%0d", seen);
        run_access(2, 1'b0, 32'h0000_0010, '0, dout, e, lat, rdy_after);
        check("abort_load_dout", dout, 32'd0);
        check("abort_load_err", {31'b0, e}, 32'd0);
        run_access(2, 1'b0, 32'h0000_0008, '0, dout, e, lat, rdy_after);
        check("reset_cleared_mem", dout, 32'd0);
        $display("after abort: load 0x10 and 0x8 -> dout=0x%08h", dout);

        // req held high: pulses expected after edges 3, 8 and 13.
        @(negedge clk);
        drive(2, 1'b1, 1'b0, 32'h0000_007C, '0);
        for (int ed = 0; ed < 16; ed++) begin
            @(posedge clk);
            #1;
            if (ed == 10) drive(2, 1'b0, 1'b0, '0, '0);
            check($sformatf("b2b_ready_e%0d", ed), {31'b0, b2.ready},
                  (ed == 3 || ed == 8 || ed == 13) ? 32'd1 : 32'd0);
            if (b2.ready)
                $display("b2b ready after edge %0d err=%0d", ed, b2.err);
        end

        // WAIT=0 instance.
        run_access(0, 1'b1, 32'h0000_0000, 32'hA5A5_A5A5, dout, e, lat, rdy_after);
        check("w0_store_lat", 32'(lat), 32'd1);
        check("w0_store_dout", dout, 32'hA5A5_A5A5);
        check("w0_store_err", {31'b0, e}, 32'd0);
        check("w0_single_pulse", {31'b0, rdy_after}, 32'd0);
        $display("w0 store 0x0 -> dout=0x%08h lat=%0d", dout, lat);
        run_access(0, 1'b0, 32'h0000_0000, '0, dout, e, lat, rdy_after);
        check("w0_load_lat", 32'(lat), 32'd1);
        check("w0_load_dout", dout, 32'hA5A5_A5A5);
        check("w0_load_err", {31'b0, e}, 32'd0);
        $display("w0 load 0x0 -> dout=0x%08h lat=%0d", dout, lat);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
